// File: rtl/gemm_acc_drain.sv
// Output stage behind the systolic MAC array: deskews per-column partial sums,
// accumulates aligned rows across K-tiles and drains finished rows over valid/ready.

module gemm_acc_drain_lane #(
    parameter int DLY = 1,
    parameter int W   = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    input  logic [W-1:0] data,
    output logic         vld_q,
    output logic [W-1:0] data_q
);
    logic [DLY-1:0]        v_pipe;
    logic [DLY-1:0][W-1:0] d_pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_pipe <= '0;
            d_pipe <= '0;
        end else begin
            v_pipe[0] <= vld;
            d_pipe[0] <= data;
            for (int i = 1; i < DLY; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                d_pipe[i] <= d_pipe[i-1];
            end
        end
    end

    assign vld_q  = v_pipe[DLY-1];
    assign data_q = d_pipe[DLY-1];
endmodule

module gemm_acc_drain #(
    parameter int N_COLS       = 4,
    parameter int P_BITWIDTH   = 24,
    parameter int ACC_BITWIDTH = 32,
    parameter int DEPTH        = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_COLS*P_BITWIDTH-1:0]     P_in,
    input  logic [N_COLS-1:0]                P_valid,
    input  logic                             tile_first,
    input  logic                             tile_last,
    output logic [N_COLS*ACC_BITWIDTH-1:0]   out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(DEPTH)-1:0]         out_row,
    output logic                             busy,
    output logic                             err_skew,
    output logic                             err_overflow
);
    localparam int RW = $clog2(DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(DEPTH-1);

    typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

    state_t state_q, state_d;
    logic [N_COLS-1:0]                   al_vld;
    logic [N_COLS-1:0][P_BITWIDTH-1:0]   al_data;
    logic [N_COLS-1:0][ACC_BITWIDTH-1:0] ext;
    logic [DEPTH-1:0][N_COLS-1:0][ACC_BITWIDTH-1:0] acc;
    logic [RW-1:0] wr_row, rd_row;
    logic row_ok, row_part;

    // Column c lags column 0 by c cycles, so it needs N_COLS-1-c stages to line up.
    for (genvar c = 0; c < N_COLS-1; c++) begin : g_lane
        gemm_acc_drain_lane #(.DLY(N_COLS-1-c), .W(P_BITWIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .vld    (P_valid[c]),
            .data   (P_in[c*P_BITWIDTH +: P_BITWIDTH]),
            .vld_q  (al_vld[c]),
            .data_q (al_data[c])
        );
    end
    assign al_vld[N_COLS-1]  = P_valid[N_COLS-1];
    assign al_data[N_COLS-1] = P_in[(N_COLS-1)*P_BITWIDTH +: P_BITWIDTH];

    assign row_ok   = &al_vld;
    assign row_part = (|al_vld) && !row_ok;

    always_comb begin
        ext = '0;
        for (int c = 0; c < N_COLS; c++)
            ext[c] = ACC_BITWIDTH'($signed(al_data[c]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ACCUM;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (row_ok && wr_row == LAST_ROW && tile_last) state_d = DRAIN;
            DRAIN: if (out_ready && rd_row == LAST_ROW) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_row   = '0;
        out_data  = '0;
        if (state_q == DRAIN) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_row   = rd_row;
            out_data  = acc[rd_row];
        end
    end

    // Rows landing while draining are discarded so the buffer stays stable for the consumer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc          <= '0;
            wr_row       <= '0;
            rd_row       <= '0;
            err_skew     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (row_part) err_skew <= 1'b1;
            if (row_ok) begin
                if (state_q == DRAIN) begin
                    err_overflow <= 1'b1;
                end else begin
                    for (int c = 0; c < N_COLS; c++)
                        acc[wr_row][c] <= tile_first ? ext[c] : acc[wr_row][c] + ext[c];
                    if (wr_row == LAST_ROW) begin
                        wr_row <= '0;
                        if (tile_last) rd_row <= '0;
                    end else begin
                        wr_row <= wr_row + 1'b1;
                    end
                end
            end
            if (state_q == DRAIN && out_ready)
                rd_row <= (rd_row == LAST_ROW) ? '0 : rd_row + 1'b1;
        end
    end
endmodule

// File: tb/tb_gemm_acc_drain.sv
// Directed bench for gemm_acc_drain: a cycle model built from input history and
// the accumulate/drain rules, plus literal expectations for each scenario.

module tb_gemm_acc_drain;
    localparam int N  = 4;
    localparam int PW = 24;
    localparam int AW = 32;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N*PW-1:0] P_in;
    logic [N-1:0]    P_valid;
    logic tile_first, tile_last, out_ready;
    logic [N*AW-1:0] out_data;
    logic out_valid, busy, err_skew, err_overflow;
    logic [$clog2(D)-1:0] out_row;

    int checks = 0;
    int errors = 0;

    gemm_acc_drain #(.N_COLS(N), .P_BITWIDTH(PW), .ACC_BITWIDTH(AW), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .P_in         (P_in),
        .P_valid      (P_valid),
        .tile_first   (tile_first),
        .tile_last    (tile_last),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .busy         (busy),
        .err_skew     (err_skew),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Model: history of sampled inputs gives the aligned row; buffer and drain tracked as plain arrays.
    logic [N-1:0]          hv [N];
    logic [N-1:0][PW-1:0]  hd [N];
    logic [AW-1:0]         macc [D][N];
    int  m_wr, m_idx;
    bit  m_drain, m_eskew, m_eovf;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin hv[k] = '0; hd[k] = '0; end
        for (int r = 0; r < D; r++) for (int c = 0; c < N; c++) macc[r][c] = '0;
        m_wr = 0; m_idx = 0; m_drain = 0; m_eskew = 0; m_eovf = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] av;
        logic [PW-1:0] ad [N];
        logic signed [AW-1:0] e;
        bit was_drain;
        for (int k = N-1; k > 0; k--) begin hv[k] = hv[k-1]; hd[k] = hd[k-1]; end
        hv[0] = P_valid;
        for (int c = 0; c < N; c++) hd[0][c] = P_in[c*PW +: PW];
        for (int c = 0; c < N; c++) begin av[c] = hv[N-1-c][c]; ad[c] = hd[N-1-c][c]; end
        was_drain = m_drain;
        if (av != '0 && av != '1) m_eskew = 1;
        if (av == '1) begin
            if (was_drain) m_eovf = 1;
            else begin
                for (int c = 0; c < N; c++) begin
                    e = $signed(ad[c]);
                    macc[m_wr][c] = tile_first ? e : macc[m_wr][c] + e;
                end
                if (m_wr == D-1) begin
                    m_wr = 0;
                    if (tile_last) begin m_drain = 1; m_idx = 0; end
                end else m_wr++;
            end
        end
        if (was_drain && out_ready) begin
            if (m_idx == D-1) m_drain = 0;
            else m_idx++;
        end
    endtask

    function automatic logic [N*AW-1:0] model_data();
        logic [N*AW-1:0] d = '0;
        if (m_drain) for (int c = 0; c < N; c++) d[c*AW +: AW] = macc[m_idx][c];
        return d;
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst) model_reset();
        chk("m_out_valid", out_valid, m_drain);
        chk("m_busy", busy, m_drain);
        chk("m_out_row", out_row, m_drain ? m_idx : 0);
        chk("m_out_data", out_data, model_data());
        chk("m_err_skew", err_skew, m_eskew);
        chk("m_err_overflow", err_overflow, m_eovf);
        if (rst) model_step();
    end

    function automatic logic [PW-1:0] lit(input int mode, input int r, input int c);
        case (mode)
            0:       return PW'(r*10 + c);
            1:       return PW'(5);
            default: return 24'hFFFFFD;
        endcase
    endfunction

    // Rows go out skewed: column c of row r in cycle r+c; skew_row delays its column 2 by one.
    task automatic send_tile(input bit first, input bit last, input int mode, input int skew_row,
                             output logic pre_valid);
        int ncyc = D + N - 1 + ((skew_row >= 0) ? 1 : 0);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            tile_first = first;
            tile_last  = last;
            P_valid = '0;
            P_in    = '0;
            for (int r = 0; r < D; r++)
                for (int c = 0; c < N; c++)
                    if (r + c + ((c == 2 && r == skew_row) ? 1 : 0) == k) begin
                        P_valid[c] = 1'b1;
                        P_in[c*PW +: PW] = lit(mode, r, c);
                    end
        end
        @(negedge clk);
        pre_valid = out_valid;
        @(posedge clk); #1;
        P_valid = '0;
        P_in    = '0;
    endtask

    task automatic single_tile_check();
        logic pre;
        send_tile(1, 1, 0, -1, pre);
        chk("single_valid_before_t3", pre, 0);
        for (int j = 0; j < D; j++) begin
            @(negedge clk);
            chk("single_valid", out_valid, 1);
            chk("single_row", out_row, j);
            for (int c = 0; c < N; c++) chk("single_lane", out_data[c*AW +: AW], j*10 + c);
        end
        @(negedge clk);
        chk("single_busy_done", busy, 0);
    endtask

    initial begin
        logic pre;
        rst = 1'b0; P_in = '0; P_valid = '0; tile_first = 1'b0; tile_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_flags", {err_skew, err_overflow}, 0);
        rst = 1'b1;

        single_tile_check();

        // Two-tile accumulate with backpressure and an overflow row during drain.
        out_ready = 1'b0;
        send_tile(1, 0, 1, -1, pre);
        chk("tileA_no_out", pre, 0);
        @(negedge clk);
        chk("between_tiles_no_out", out_valid, 0);
        send_tile(0, 1, 2, -1, pre);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_row", out_row, 0);
            for (int c = 0; c < N; c++) chk("bp_lane", out_data[c*AW +: AW], 32'h00000002);
            @(posedge clk); #1;
            P_valid = '0;
            P_in    = '0;
            if (i < N) begin
                P_valid[i] = 1'b1;
                P_in[i*PW +: PW] = PW'(99);
            end else out_ready = 1'b1;
        end
        for (int j = 0; j < D; j++) begin
            @(negedge clk);
            chk("ovf_flag", err_overflow, 1);
            chk("acc_row", out_row, j);
            for (int c = 0; c < N; c++) chk("acc_lane", out_data[c*AW +: AW], 32'h00000002);
        end
        @(negedge clk);
        chk("acc_busy_done", busy, 0);

        // Skewed row 1, then reset mid-stream and a fresh tile.
        send_tile(1, 0, 0, 1, pre);
        @(negedge clk);
        chk("skew_flag", err_skew, 1);
        chk("skew_no_drain", out_valid, 0);
        @(posedge clk); #1;
        P_valid = '1;
        P_in = {PW'(7), PW'(7), PW'(7), PW'(7)};
        tile_first = 1'b1;
        tile_last  = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_flags", {err_skew, err_overflow}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        P_valid = '0;
        P_in    = '0;

        single_tile_check();
        chk("final_flags", {err_skew, err_overflow}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
